preddr_packer: RTL and testbench
================================

Name: preddr_packer

Overview:
Parametrised, single-clock successor to the fixed 18/8-bit pre-DDR assembler. It packs samples of runtime-selectable width, 1..MAX_WIDTH bits, densely and MSB-first into OUT_WIDTH-bit words, with no per-mode slicing tables. On capture end it emits a zero-padded final word and then a done pulse. Words are buffered in an internal first-word-fall-through (FWFT) FIFO with a valid/read handshake; it sits between the capture front-end and the DDR write path, with CDC handled outside the block.

Parameters:
MAX_WIDTH, 18, largest sample width in bits; must be <= OUT_WIDTH.
OUT_WIDTH, 64, output word width.
DEPTH, 16, output FIFO depth in words; power of 2, >= 2.
CNT_WIDTH, 24, width of the accepted-word counter.

Ports:
clk  in  1  sole clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
capture_start  in  1  pulse: clears packer, FIFO, counters and flags; latches I_sample_width.
capture_done  in  1  pulse: end of capture; triggers flush.
I_sample_width  in  5  sample width, valid range 1..MAX_WIDTH.
I_data  in  MAX_WIDTH  sample; the low I_sample_width bits are used.
I_wr  in  1  sample strobe.
O_rd  in  1  pop the FIFO head.
O_data  out  OUT_WIDTH  FIFO head word; valid while O_valid.
O_valid  out  1  FIFO not empty.
O_done  out  1  one-cycle pulse after the final word has been written.
O_word_count  out  CNT_WIDTH  words accepted into the FIFO this capture; saturates at all-ones.
O_errors  out  2  {overflow_sticky, underflow_sticky}.
clear_errors  in  1  clears both sticky flags.

Behaviour:
- Reset (reset_n=0, asynchronous): FSM=IDLE; accumulator, fill count, FIFO pointers, O_word_count and stickies all 0. O_valid=0, O_done=0, O_data=0.
- FSM states:
  - IDLE -> RUN on capture_start.
  - RUN -> FLUSH on capture_done.
  - FLUSH -> DONE after exactly 1 cycle.
  - DONE -> IDLE after 1 cycle; O_done=1 only in DONE.
  - capture_start in any state forces RUN with everything cleared; this takes priority over I_wr and capture_done in the same cycle.
- Width latch: the effective width W is latched at capture_start. Values 0 or >MAX_WIDTH latch as MAX_WIDTH. Changes mid-capture are ignored.
- Packing (RUN, I_wr=1):
  - Append the W bits below all previously held bits; fill += W.
  - If fill >= OUT_WIDTH, the top OUT_WIDTH bits form a complete word and are pushed to the FIFO on the next edge (latency 1: O_valid rises 1 cycle after the completing I_wr). The remainder of fill-OUT_WIDTH bits stays MSB-aligned.
  - At most one word completes per sample.
  - The accumulator is OUT_WIDTH+MAX_WIDTH bits.
- Same-cycle I_wr and capture_done: the sample is packed first, then the flush follows.
- FLUSH: if fill>0, push the remaining bits MSB-aligned with zeros below them, then set fill=0. If fill=0, no push occurs.
- I_wr in IDLE, FLUSH or DONE is ignored.
- FIFO:
  - FWFT: O_data holds the head word whenever O_valid=1.
  - O_rd with O_valid=1 pops on that edge.
  - Simultaneous push and pop on a full FIFO succeeds.
  - Push with FIFO full and no pop: word dropped, overflow_sticky set, O_word_count not incremented.
  - O_rd with O_valid=0: no effect, underflow_sticky set.
- Stickies: cleared by clear_errors or capture_start. A set event in the same cycle as a clear wins.
- O_word_count: increments per accepted push and holds after DONE until the next capture_start.

Test Plan:
- W=4, I_data=0..F over 16 consecutive I_wr -> one word 0x0123456789ABCDEF, O_valid 1 cycle after the 16th I_wr, O_word_count=1.
- W=18, 32 samples of 0x3FFFF then capture_done -> exactly 9 words of all-ones, no pad word, O_done 2 cycles after capture_done, O_word_count=9.
- W=18, samples 1,2,3,4,5 then capture_done -> word0 = bits of 1,2,3 plus the top 10 bits of 4; word1 = the low 8 bits of 4, then 5, then 38 zero bits; O_done follows.
- DEPTH=4, W=16, no O_rd, 20 samples -> 5 words attempted, 4 stored, O_errors=2'b10, O_word_count=4. Then O_rd on an empty FIFO -> O_errors=2'b11. clear_errors -> 2'b00.
- I_wr and capture_done in the same cycle, W=8, 3 samples -> the third sample is included; pad word 0xAABBCC0000000000 for samples AA,BB,CC.
- reset_n pulsed low mid-capture and asynchronously (between edges) -> O_valid, O_word_count, O_errors all 0 immediately; FSM=IDLE; following I_wr ignored until capture_start.

Source files
------------

// File: rtl/preddr_packer_if.sv
// Sample-in / word-out bus of the pre-DDR packer.
// The producer/consumer side uses master; the packer uses slave.
interface preddr_packer_if #(
  parameter int MAX_WIDTH = 18,
  parameter int OUT_WIDTH = 64
) ();
  logic [MAX_WIDTH-1:0] I_data;
  logic                 I_wr;
  logic                 O_rd;
  logic [OUT_WIDTH-1:0] O_data;
  logic                 O_valid;

  modport master (output I_data, I_wr, O_rd, input O_data, O_valid);
  modport slave  (input I_data, I_wr, O_rd, output O_data, O_valid);
endinterface

// File: rtl/preddr_packer.sv
// Pre-DDR packer: packs variable-width samples MSB-first into OUT_WIDTH-bit
// words, zero-pads the tail on capture end, and buffers words in a FWFT FIFO.
module preddr_packer #(
  parameter int MAX_WIDTH = 18,
  parameter int OUT_WIDTH = 64,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 capture_start,
  input  logic                 capture_done,
  input  logic [4:0]           I_sample_width,
  input  logic                 clear_errors,
  preddr_packer_if.slave       bus,
  output logic                 O_done,
  output logic [CNT_WIDTH-1:0] O_word_count,
  output logic [1:0]           O_errors
);

  localparam int ACC_W = OUT_WIDTH + MAX_WIDTH;
  localparam int FW    = $clog2(ACC_W + 1);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             w_q, w_eff;
  logic [ACC_W-1:0]       acc_q, acc_d, samp_ext, acc_ins;
  logic [FW-1:0]          fill_q, fill_d, fill_ins;
  logic [MAX_WIDTH-1:0]   samp_mask;
  logic                   push_req;
  logic [OUT_WIDTH-1:0]   push_word;

  logic [OUT_WIDTH-1:0]   mem [DEPTH];
  logic [AW:0]            wr_q, rd_q;
  logic                   empty, full, pop, push_ok, ovf_ev, udf_ev;
  logic                   ovf_q, udf_q;

  // Out-of-range widths fall back to the widest sample.
  always_comb begin
    w_eff = I_sample_width;
    if (I_sample_width == 5'd0 || I_sample_width > 5'(MAX_WIDTH)) w_eff = 5'(MAX_WIDTH);
  end

  // Insert the new sample directly below the bits already held (MSB-aligned).
  always_comb begin
    samp_mask = bus.I_data & ~({MAX_WIDTH{1'b1}} << w_q);
    samp_ext  = ACC_W'(samp_mask) << (FW'(ACC_W) - FW'(w_q));
    acc_ins   = acc_q | (samp_ext >> fill_q);
    fill_ins  = fill_q + FW'(w_q);
  end

  // FSM next state; capture_start overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_RUN:   if (capture_done) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (capture_start) state_d = S_RUN;
  end

  // Accumulator update and word push request (pack in RUN, pad-out in FLUSH).
  always_comb begin
    acc_d     = acc_q;
    fill_d    = fill_q;
    push_req  = 1'b0;
    push_word = acc_q[ACC_W-1 -: OUT_WIDTH];
    if (capture_start) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (state_q == S_RUN && bus.I_wr) begin
      if (fill_ins >= FW'(OUT_WIDTH)) begin
        push_req  = 1'b1;
        push_word = acc_ins[ACC_W-1 -: OUT_WIDTH];
        acc_d     = acc_ins << OUT_WIDTH;
        fill_d    = fill_ins - FW'(OUT_WIDTH);
      end else begin
        acc_d  = acc_ins;
        fill_d = fill_ins;
      end
    end else if (state_q == S_FLUSH && fill_q != '0) begin
      // Bits below the fill point are always zero, so the head is already padded.
      push_req = 1'b1;
      acc_d    = '0;
      fill_d   = '0;
    end
  end

  // Packer state, accumulator and latched width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      fill_q  <= '0;
      w_q     <= 5'(MAX_WIDTH);
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      if (capture_start) w_q <= w_eff;
    end
  end

  // FIFO flags and events; a pop frees the slot a same-cycle push needs.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop     = bus.O_rd && !empty && !capture_start;
    push_ok = push_req && (!full || pop);
    ovf_ev  = push_req && full && !pop;
    udf_ev  = bus.O_rd && empty && !capture_start;
  end

  // FIFO storage, no reset needed: reads are gated by the empty flag.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= push_word;
  end

  // FIFO pointers, word counter and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q         <= '0;
      rd_q         <= '0;
      O_word_count <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else if (capture_start) begin
      wr_q         <= '0;
      rd_q         <= '0;
      O_word_count <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (push_ok && O_word_count != '1) O_word_count <= O_word_count + 1'b1;
      // A set in the same cycle as a clear wins.
      if (ovf_ev)            ovf_q <= 1'b1;
      else if (clear_errors) ovf_q <= 1'b0;
      if (udf_ev)            udf_q <= 1'b1;
      else if (clear_errors) udf_q <= 1'b0;
    end
  end

  assign bus.O_valid = !empty;
  assign bus.O_data  = empty ? '0 : mem[rd_q[AW-1:0]];
  assign O_done      = (state_q == S_DONE);
  assign O_errors    = {ovf_q, udf_q};

endmodule

// File: tb/tb_preddr_packer.sv
// Self-checking bench for preddr_packer against a bit-stream reference model.
module tb_preddr_packer;
  localparam int MW = 18;
  localparam int OW = 64;
  localparam int DP = 4;
  localparam int CW = 24;

  logic          clk, reset_n, capture_start, capture_done, clear_errors;
  logic [4:0]    I_sample_width;
  logic          O_done;
  logic [CW-1:0] O_word_count;
  logic [1:0]    O_errors;

  int checks = 0;
  int failures = 0;

  logic [OW-1:0] got_q[$];
  logic [OW-1:0] exp_q[$];
  bit rd_en = 0, rand_rd = 0, force_rd = 0;

  preddr_packer_if #(.MAX_WIDTH(MW), .OUT_WIDTH(OW)) bus ();

  preddr_packer #(.MAX_WIDTH(MW), .OUT_WIDTH(OW), .DEPTH(DP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .capture_start(capture_start),
    .capture_done(capture_done), .I_sample_width(I_sample_width),
    .clear_errors(clear_errors), .bus(bus), .O_done(O_done),
    .O_word_count(O_word_count), .O_errors(O_errors));

  initial clk = 0;
  always #5 clk = ~clk;

  // Consumer: decides O_rd at the falling edge and logs every popped word.
  always @(negedge clk) begin
    bus.O_rd = force_rd || (rd_en && bus.O_valid && (!rand_rd || $urandom_range(0, 3) != 0));
    if (bus.O_rd && bus.O_valid) got_q.push_back(bus.O_data);
  end

  function automatic int eff_w(input int w);
    return (w == 0 || w > MW) ? MW : w;
  endfunction

  // Reference: serialise samples into a bit stream, cut 64-bit words, pad the tail.
  task automatic model_build(input int w, input logic [MW-1:0] s[$]);
    bit b[$];
    logic [OW-1:0] wd;
    exp_q.delete();
    foreach (s[k]) begin
      for (int i = w - 1; i >= 0; i--) b.push_back(s[k][i]);
      if (b.size() >= OW) begin
        for (int j = 0; j < OW; j++) wd[OW-1-j] = b.pop_front();
        exp_q.push_back(wd);
      end
    end
    if (b.size() > 0) begin
      int n = b.size();
      wd = '0;
      for (int j = 0; j < n; j++) wd[OW-1-j] = b.pop_front();
      exp_q.push_back(wd);
    end
  endtask

  task automatic do_start(input int w);
    capture_start = 1; I_sample_width = w[4:0];
    @(posedge clk); #1;
    capture_start = 0;
  endtask

  task automatic do_wr(input logic [MW-1:0] d);
    bus.I_wr = 1; bus.I_data = d;
    @(posedge clk); #1;
    bus.I_wr = 0;
  endtask

  // Full capture: start, samples (optional idle gaps), capture_done. Ends in FLUSH.
  task automatic run_capture(input int w, input logic [MW-1:0] s[$], input bit gaps, input bit done_last);
    do_start(w);
    for (int k = 0; k < s.size(); k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.I_wr = 1; bus.I_data = s[k];
      if (done_last && k == s.size() - 1) capture_done = 1;
      @(posedge clk); #1;
      bus.I_wr = 0; capture_done = 0;
    end
    if (!done_last) begin
      capture_done = 1;
      @(posedge clk); #1;
      capture_done = 0;
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    #2;
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.O_valid); end
    checks++; if (O_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", O_done); end
    checks++; if (bus.O_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.O_data); end
    checks++; if (O_word_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", O_word_count); end
    checks++; if (O_errors !== 2'b00) begin failures++; $display("FAIL reset_errors got=%b exp=00", O_errors); end
    #10 reset_n = 1;
    @(posedge clk); #1;
    // Samples in IDLE must be ignored.
    for (int i = 0; i < 20; i++) do_wr(MW'($urandom));
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL idle_wr_valid got=%b exp=0", bus.O_valid); end
    checks++; if (O_word_count !== '0) begin failures++; $display("FAIL idle_wr_count got=%0d exp=0", O_word_count); end
  endtask

  task automatic test_w4();
    rd_en = 0;
    do_start(4);
    for (int i = 0; i < 15; i++) do_wr(MW'(i));
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL w4_early_valid got=%b exp=0", bus.O_valid); end
    do_wr(MW'(15));
    checks++; if (bus.O_valid !== 1'b1) begin failures++; $display("FAIL w4_valid got=%b exp=1", bus.O_valid); end
    checks++; if (bus.O_data !== 64'h0123456789ABCDEF) begin failures++; $display("FAIL w4_data got=%h exp=0123456789abcdef", bus.O_data); end
    checks++; if (O_word_count !== 24'd1) begin failures++; $display("FAIL w4_count got=%0d exp=1", O_word_count); end
    force_rd = 1; @(posedge clk); #1; force_rd = 0;
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL w4_pop_valid got=%b exp=0", bus.O_valid); end
    capture_done = 1; @(posedge clk); #1; capture_done = 0;
    checks++; if (O_done !== 1'b0) begin failures++; $display("FAIL w4_done_early got=%b exp=0", O_done); end
    @(posedge clk); #1;
    checks++; if (O_done !== 1'b1) begin failures++; $display("FAIL w4_done got=%b exp=1", O_done); end
    @(posedge clk); #1;
    checks++; if (O_done !== 1'b0) begin failures++; $display("FAIL w4_done_pulse got=%b exp=0", O_done); end
    checks++; if (O_word_count !== 24'd1 || bus.O_valid !== 1'b0) begin failures++; $display("FAIL w4_no_pad got=%0d/%b exp=1/0", O_word_count, bus.O_valid); end
  endtask

  // Shared comparison body is written out per test to keep each self-contained.
  task automatic test_ones();
    logic [MW-1:0] s[$];
    for (int i = 0; i < 32; i++) s.push_back(18'h3FFFF);
    model_build(18, s);
    got_q.delete(); rd_en = 1; rand_rd = 0;
    run_capture(18, s, 0, 0);
    checks++; if (O_done !== 1'b0) begin failures++; $display("FAIL ones_done_early got=%b exp=0", O_done); end
    @(posedge clk); #1;
    checks++; if (O_done !== 1'b1) begin failures++; $display("FAIL ones_done got=%b exp=1", O_done); end
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != 9 || exp_q.size() != 9) begin failures++; $display("FAIL ones_words got=%0d exp=9", got_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (got_q[i] !== '1) begin failures++; $display("FAIL ones_word%0d got=%h exp=all-ones", i, got_q[i]); end
    end
    checks++; if (O_word_count !== 24'd9) begin failures++; $display("FAIL ones_count got=%0d exp=9", O_word_count); end
  endtask

  task automatic test_partial();
    logic [MW-1:0] s[$] = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd5};
    model_build(18, s);
    got_q.delete(); rd_en = 1; rand_rd = 0;
    run_capture(18, s, 0, 0);
    @(posedge clk); #1;
    checks++; if (O_done !== 1'b1) begin failures++; $display("FAIL partial_done got=%b exp=1", O_done); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL partial_words got=%0d exp=2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== ((64'd1 << 46) | (64'd2 << 28) | (64'd3 << 10))) begin failures++; $display("FAIL partial_w0 got=%h", got_q[0]); end
      checks++; if (got_q[1] !== ((64'h04 << 56) | (64'd5 << 38))) begin failures++; $display("FAIL partial_w1 got=%h", got_q[1]); end
      checks++; if (got_q[1] !== exp_q[1]) begin failures++; $display("FAIL partial_model got=%h exp=%h", got_q[1], exp_q[1]); end
    end
  endtask

  task automatic test_same_cycle();
    logic [MW-1:0] s[$] = '{18'hAA, 18'hBB, 18'hCC};
    got_q.delete(); rd_en = 1; rand_rd = 0;
    run_capture(8, s, 0, 1);
    @(posedge clk); #1;
    checks++; if (O_done !== 1'b1) begin failures++; $display("FAIL same_done got=%b exp=1", O_done); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != 1 || got_q[0] !== 64'hAABBCC0000000000) begin
      failures++; $display("FAIL same_pad got=%0d words first=%h exp=1 aabbcc0000000000", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
    end
    checks++; if (O_word_count !== 24'd1) begin failures++; $display("FAIL same_count got=%0d exp=1", O_word_count); end
  endtask

  task automatic test_full_push_pop();
    logic [MW-1:0] s[$];
    for (int i = 0; i < 20; i++) s.push_back(MW'($urandom));
    model_build(16, s);
    got_q.delete(); rd_en = 0;
    do_start(16);
    for (int k = 0; k < 19; k++) do_wr(s[k]);
    force_rd = 1; do_wr(s[19]); force_rd = 0;
    checks++; if (O_errors !== 2'b00) begin failures++; $display("FAIL fpp_errors got=%b exp=00", O_errors); end
    checks++; if (O_word_count !== 24'd5) begin failures++; $display("FAIL fpp_count got=%0d exp=5", O_word_count); end
    force_rd = 1; repeat (4) begin @(posedge clk); #1; end force_rd = 0;
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL fpp_words got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fpp_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [MW-1:0] s[$];
    for (int i = 0; i < 20; i++) s.push_back(MW'($urandom));
    model_build(16, s);
    got_q.delete(); rd_en = 0;
    do_start(16);
    foreach (s[k]) do_wr(s[k]);
    checks++; if (O_errors !== 2'b10) begin failures++; $display("FAIL ovf_errors got=%b exp=10", O_errors); end
    checks++; if (O_word_count !== 24'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", O_word_count); end
    force_rd = 1; repeat (4) begin @(posedge clk); #1; end force_rd = 0;
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL ovf_words got=%0d exp=4", got_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    force_rd = 1; @(posedge clk); #1; force_rd = 0;
    checks++; if (O_errors !== 2'b11) begin failures++; $display("FAIL udf_errors got=%b exp=11", O_errors); end
    clear_errors = 1; force_rd = 1; @(posedge clk); #1; clear_errors = 0; force_rd = 0;
    checks++; if (O_errors !== 2'b01) begin failures++; $display("FAIL set_wins got=%b exp=01", O_errors); end
    clear_errors = 1; @(posedge clk); #1; clear_errors = 0;
    checks++; if (O_errors !== 2'b00) begin failures++; $display("FAIL clear_errors got=%b exp=00", O_errors); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [MW-1:0] s[$];
      int w, n, cnt;
      w = $urandom_range(0, 20);
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) s.push_back(MW'($urandom));
      model_build(eff_w(w), s);
      got_q.delete(); rd_en = 1; rand_rd = 1;
      run_capture(w, s, $urandom_range(0, 1), $urandom_range(0, 1));
      @(posedge clk); #1;
      checks++; if (O_done !== 1'b1) begin failures++; $display("FAIL rnd%0d_done got=%b exp=1", it, O_done); end
      cnt = 0;
      while (got_q.size() < exp_q.size() && cnt < 100) begin @(posedge clk); #1; cnt++; end
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd%0d_words w=%0d got=%0d exp=%0d", it, w, got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_word%0d w=%0d got=%h exp=%h", it, i, w, got_q[i], exp_q[i]); end
      end
      checks++; if (O_word_count !== CW'(exp_q.size())) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, O_word_count, exp_q.size()); end
      checks++; if (O_errors !== 2'b00) begin failures++; $display("FAIL rnd%0d_errors got=%b exp=00", it, O_errors); end
    end
    rd_en = 0; rand_rd = 0;
  endtask

  task automatic test_async_reset();
    logic [MW-1:0] s[$];
    rd_en = 0;
    do_start(8);
    for (int i = 0; i < 48; i++) do_wr(MW'($urandom));
    checks++; if (O_errors !== 2'b10 || O_word_count !== 24'd4) begin failures++; $display("FAIL ar_setup got=%b/%0d exp=10/4", O_errors, O_word_count); end
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", bus.O_valid); end
    checks++; if (O_word_count !== '0) begin failures++; $display("FAIL ar_count got=%0d exp=0", O_word_count); end
    checks++; if (O_errors !== 2'b00) begin failures++; $display("FAIL ar_errors got=%b exp=00", O_errors); end
    @(negedge clk); #2;
    reset_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) do_wr(MW'($urandom));
    checks++; if (bus.O_valid !== 1'b0 || O_word_count !== '0) begin failures++; $display("FAIL ar_idle got=%b/%0d exp=0/0", bus.O_valid, O_word_count); end
    for (int i = 0; i < 8; i++) s.push_back(MW'($urandom));
    model_build(8, s);
    do_start(8);
    foreach (s[k]) do_wr(s[k]);
    checks++; if (O_word_count !== 24'd1 || bus.O_data !== exp_q[0]) begin failures++; $display("FAIL ar_restart got=%0d/%h exp=1/%h", O_word_count, bus.O_data, exp_q[0]); end
  endtask

  initial begin
    reset_n = 0; capture_start = 0; capture_done = 0; clear_errors = 0;
    I_sample_width = 5'd0; bus.I_wr = 0; bus.I_data = '0;
    test_reset();
    test_w4();
    test_ones();
    test_partial();
    test_same_cycle();
    test_full_push_pop();
    test_overflow();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
